clk_meas: RTL and testbench

CLK_MEAS -- requirements
Module: clk_meas

---
 rtl/clk_meas.sv | 112 +++++++++++
 tb/tb_clk_meas.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meas.sv
// Measures period and high time of a slow clock clk_s_i in clk_i cycles.
// Define CLK_MEAS_SYNC_EN when clk_s_i is asynchronous to clk_i (adds a synchronizer stage).
module clk_meas #(
    parameter int CW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clk_s_i,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] high_o,
    output logic          valid_o,
    output logic          stable_o,
    output logic          err_o
);

    typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;

    localparam logic [CW-1:0] CMAX = '1;

    state_t        state, state_nxt;
    logic          s_q, s_d;
    logic          rise, tmo, capture;
    logic [CW-1:0] cnt, hcnt;

`ifdef CLK_MEAS_SYNC_EN
    // meta and s_q form the two-flop synchronizer; s_q is its settled output
    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            meta <= clk_s_i;
            s_q  <= meta;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) s_q <= 1'b0;
        else       s_q <= clk_s_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) s_d <= 1'b0;
        else       s_d <= s_q;
    end

    assign rise    = s_q & ~s_d;
    // a rise landing on the saturated count still closes a valid period
    assign tmo     = (state == MEAS) && (cnt == CMAX) && !rise;
    assign capture = en_i && (state == MEAS) && rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (rise) state_nxt = MEAS;
                MEAS:    if (tmo)  state_nxt = SYNC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE || !en_i) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CW'(1);
            hcnt <= CW'(1);
        end else begin
            if (cnt != CMAX)         cnt  <= cnt + CW'(1);
            if (s_q && hcnt != CMAX) hcnt <= hcnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
            stable_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (!en_i) begin
                stable_o <= 1'b0;
                err_o    <= 1'b0;
            end else if (capture) begin
                period_o <= cnt;
                high_o   <= hcnt;
                valid_o  <= 1'b1;
                stable_o <= (cnt == period_o);
            end else if (tmo) begin
                err_o    <= 1'b1;
                stable_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: default-width instance for period/duty/enable/reset,
// CW=4 instance for timeout and rise-vs-timeout priority.
module tb_clk_meas;

    logic       clk_i = 1'b0;
    logic       rst_i, en_i, clk_s, en4, s4;
    logic [9:0] period_o, high_o;
    logic       valid_o, stable_o, err_o;
    logic [3:0] period4, high4;
    logic       valid4, stable4, err4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        logic [9:0] per;
        logic [9:0] hi;
        logic       st;
    } vrec_t;
    vrec_t recs[$];

    always #5 clk_i = ~clk_i;

    clk_meas #(.CW(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clk_s_i(clk_s),
        .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
        .stable_o(stable_o), .err_o(err_o)
    );

    clk_meas #(.CW(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en4), .clk_s_i(s4),
        .period_o(period4), .high_o(high4), .valid_o(valid4),
        .stable_o(stable4), .err_o(err4)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // n periods of hi/lo on clk_s; records every valid_o with its tick index
    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            clk_s = 1'b1;
            for (int k = 0; k < hi + lo; k++) begin
                if (k == hi) clk_s = 1'b0;
                tick();
                if (valid_o)
                    recs.push_back('{p * (hi + lo) + k, period_o, high_o, stable_o});
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; clk_s = 1'b0; en4 = 1'b0; s4 = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        checks++;
        if (period_o !== 10'd0 || high_o !== 10'd0) begin
            errors++; $display("FAIL reset_meas: got per=%0d hi=%0d want 0 0", period_o, high_o);
        end
        checks++;
        if ({valid_o, stable_o, err_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got v/s/e=%b want 000", {valid_o, stable_o, err_o});
        end
        checks++;
        if ({period4, high4, valid4, stable4, err4} !== 11'd0) begin
            errors++; $display("FAIL reset_cw4: got %h want 0", {period4, high4, valid4, stable4, err4});
        end
    endtask

    task automatic test_basic();
        int ei[2] = '{11, 21};
        int ep[2] = '{10, 10};
        int eh[2] = '{5, 5};
        int es[2] = '{0, 1};
        en_i = 1'b1; clk_s = 1'b0;
        tick(); tick();
        recs.delete();
        wave(5, 5, 3);
        checks++;
        if (recs.size() != 2) begin
            errors++; $display("FAIL basic_count: got %0d valids want 2", recs.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= recs.size()) begin
                errors++; $display("FAIL basic_rec%0d: got none want valid", i);
            end else if (recs[i].idx != ei[i] || recs[i].per !== ep[i] || recs[i].hi !== eh[i] || recs[i].st !== es[i]) begin
                errors++;
                $display("FAIL basic_rec%0d: got idx=%0d per=%0d hi=%0d st=%0d want idx=%0d per=%0d hi=%0d st=%0d",
                         i, recs[i].idx, recs[i].per, recs[i].hi, recs[i].st, ei[i], ep[i], eh[i], es[i]);
            end
        end
    endtask

    task automatic test_period_change();
        int ei[6] = '{1, 13, 25, 1, 11, 21};
        int ep[6] = '{10, 12, 12, 12, 10, 10};
        int eh[6] = '{5, 6, 6, 6, 5, 5};
        int es[6] = '{1, 0, 1, 1, 0, 1};
        recs.delete();
        wave(6, 6, 3);
        wave(5, 5, 3);
        checks++;
        if (recs.size() != 6) begin
            errors++; $display("FAIL chg_count: got %0d valids want 6", recs.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= recs.size()) begin
                errors++; $display("FAIL chg_rec%0d: got none want valid", i);
            end else if (recs[i].idx != ei[i] || recs[i].per !== ep[i] || recs[i].hi !== eh[i] || recs[i].st !== es[i]) begin
                errors++;
                $display("FAIL chg_rec%0d: got idx=%0d per=%0d hi=%0d st=%0d want idx=%0d per=%0d hi=%0d st=%0d",
                         i, recs[i].idx, recs[i].per, recs[i].hi, recs[i].st, ei[i], ep[i], eh[i], es[i]);
            end
        end
    endtask

    // drop enable exactly while a rise is pending: no capture, flags cleared
    task automatic test_en_drop();
        clk_s = 1'b1;
        tick();
        en_i = 1'b0;
        tick();
        checks++;
        if ({valid_o, stable_o, err_o} !== 3'b000) begin
            errors++; $display("FAIL endrop_flags: got v/s/e=%b want 000", {valid_o, stable_o, err_o});
        end
        checks++;
        if (period_o !== 10'd10 || high_o !== 10'd5) begin
            errors++; $display("FAIL endrop_hold: got per=%0d hi=%0d want 10 5", period_o, high_o);
        end
        tick(); tick();
        checks++;
        if (period_o !== 10'd10 || valid_o !== 1'b0) begin
            errors++; $display("FAIL endrop_idle: got per=%0d v=%b want 10 0", period_o, valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int ei[2] = '{11, 21};
        int es[2] = '{0, 1};
        en_i = 1'b1; clk_s = 1'b0;
        tick(); tick();
        wave(5, 5, 2);
        clk_s = 1'b1;
        repeat (6) tick();
        clk_s = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({period_o, high_o, valid_o, stable_o, err_o} !== 23'd0) begin
            errors++; $display("FAIL rstmid_out: got per=%0d hi=%0d v/s/e=%b want all 0",
                               period_o, high_o, {valid_o, stable_o, err_o});
        end
        recs.delete();
        wave(5, 5, 3);
        checks++;
        if (recs.size() != 2) begin
            errors++; $display("FAIL rstmid_count: got %0d valids want 2", recs.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= recs.size()) begin
                errors++; $display("FAIL rstmid_rec%0d: got none want valid", i);
            end else if (recs[i].idx != ei[i] || recs[i].per !== 10'd10 || recs[i].hi !== 10'd5 || recs[i].st !== es[i]) begin
                errors++;
                $display("FAIL rstmid_rec%0d: got idx=%0d per=%0d hi=%0d st=%0d want idx=%0d per=10 hi=5 st=%0d",
                         i, recs[i].idx, recs[i].per, recs[i].hi, recs[i].st, ei[i], es[i]);
            end
        end
    endtask

    task automatic test_duty();
        int ei[2] = '{11, 21};
        int es[2] = '{0, 1};
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        recs.delete();
        wave(1, 9, 3);
        checks++;
        if (recs.size() != 2) begin
            errors++; $display("FAIL duty_count: got %0d valids want 2", recs.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= recs.size()) begin
                errors++; $display("FAIL duty_rec%0d: got none want valid", i);
            end else if (recs[i].idx != ei[i] || recs[i].per !== 10'd10 || recs[i].hi !== 10'd1 || recs[i].st !== es[i]) begin
                errors++;
                $display("FAIL duty_rec%0d: got idx=%0d per=%0d hi=%0d st=%0d want idx=%0d per=10 hi=1 st=%0d",
                         i, recs[i].idx, recs[i].per, recs[i].hi, recs[i].st, ei[i], es[i]);
            end
        end
    endtask

    // CW=4: rise arrives in the same cycle the count sits at 15
    task automatic test_rise_priority();
        en4 = 1'b1; s4 = 1'b0;
        tick(); tick();
        s4 = 1'b1; tick();
        s4 = 1'b0; tick();
        repeat (13) tick();
        s4 = 1'b1; tick();
        s4 = 1'b0; tick();
        checks++;
        if (valid4 !== 1'b1 || period4 !== 4'd15 || high4 !== 4'd1 || err4 !== 1'b0) begin
            errors++; $display("FAIL prio: got v=%b per=%0d hi=%0d err=%b want 1 15 1 0",
                               valid4, period4, high4, err4);
        end
    endtask

    task automatic test_timeout();
        int nvalid = 0;
        repeat (14) begin
            tick();
            if (valid4) nvalid++;
        end
        checks++;
        if (err4 !== 1'b0) begin
            errors++; $display("FAIL tmo_early: got err=%b want 0", err4);
        end
        tick();
        if (valid4) nvalid++;
        checks++;
        if (err4 !== 1'b1 || stable4 !== 1'b0) begin
            errors++; $display("FAIL tmo_fire: got err=%b st=%b want 1 0", err4, stable4);
        end
        repeat (10) begin
            tick();
            if (valid4) nvalid++;
        end
        checks++;
        if (err4 !== 1'b1) begin
            errors++; $display("FAIL tmo_sticky: got err=%b want 1", err4);
        end
        checks++;
        if (nvalid != 0) begin
            errors++; $display("FAIL tmo_novalid: got %0d valids want 0", nvalid);
        end
        en4 = 1'b0;
        tick();
        checks++;
        if (err4 !== 1'b0 || period4 !== 4'd15) begin
            errors++; $display("FAIL tmo_clear: got err=%b per=%0d want 0 15", err4, period4);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period_change();
        test_en_drop();
        test_reset_mid();
        test_duty();
        test_rise_priority();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
